dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
//  Sequencer for the DDS datapath (phase_adder -> waveform ROM/DAC). Accepts a sweep descriptor:
//  start/stop frequency word, step, dwell, mode, wave select and PWM duty.
//  Steps freq_word through the sweep at clk_100m rate. Changes to wave_word/pwm_word are
//  committed only on an accumulator wrap, so the DAC never shows a torn period.
//  Sits between the user/config logic and the phase accumulator + wave mux in toplevel.
// PARAMETERS
//  FREQ_W   20  width of frequency control word (fout = 100e6/2^28 * freq_word)
//  DWELL_W  24  width of dwell counter (clk_100m cycles per frequency point)
//  PWM_W    7   width of PWM duty word
// PORTS
//  clk_100m      in   1        system clock (PLL c0)
//  rst_n         in   1        async active-low reset
//  cfg_valid     in   1        descriptor valid
//  cfg_ready     out  1        descriptor accepted when cfg_valid & cfg_ready
//  cfg_start     in   FREQ_W   first frequency word
//  cfg_stop      in   FREQ_W   last frequency word
//  cfg_step      in   FREQ_W   unsigned step magnitude
//  cfg_dwell     in   DWELL_W  cycles per point (0 treated as 1)
//  cfg_mode      in   2        00 single, 01 repeat (sawtooth), 10 ping-pong, 11 reserved = single
//  cfg_wave      in   2        00 sin, 01 tri, 10 square, 11 PWM
//  cfg_pwm       in   PWM_W    PWM duty word
//  abort         in   1        stop sweep, return to IDLE
//  phase_wrap    in   1        1-cycle pulse when phase accumulator overflows
//  dds_enable    out  1        enable to datapath; high while busy or holding a final point
//  freq_word     out  FREQ_W   to phase_adder dataa
//  wave_word     out  2        to wave mux (committed on wrap)
//  pwm_word      out  PWM_W    to PWM comparator (committed on wrap)
//  busy          out  1        sweep in progress
//  done          out  1        1-cycle pulse when a single sweep completes
// BEHAVIOUR
//  Reset: state IDLE; freq_word=0; wave_word=0; pwm_word=0; dds_enable=0; busy=0; done=0; cfg_ready=1.
//  States: IDLE, DWELL, STEP, HOLD. cfg_ready=1 only in IDLE and HOLD.
//  Accept (cycle N), from IDLE or HOLD: latch descriptor.
//   - freq_word=cfg_start at N+1.
//   - dir=up if cfg_stop>=cfg_start, else down.
//   - Dwell counter loaded; state DWELL; busy=1; dds_enable=1.
//   - cfg_wave/cfg_pwm go to shadow regs and set pending.
//  DWELL: counter decrements each cycle; after exactly max(dwell,1) cycles at a point, go to STEP.
//  STEP (1 cycle; freq_word unchanged during it), then return to DWELL.
//   - If freq_word != target: freq_word = freq_word +/- step, clamped to target.
//     Overshoot and unsigned wrap are both clamped; the comparison is done at FREQ_W+1 bits.
//   - If freq_word == target:
//     - single: HOLD, done pulse, busy=0; freq_word stays at stop.
//     - repeat: freq_word=start.
//     - ping-pong: target/dir swap; first move takes effect in this STEP.
//   - step==0: point never moves. Single completes after one dwell; repeat/ping-pong loop at start.
//   - Point period = dwell+1 cycles (DWELL + STEP).
//  Wave/PWM commit: while pending, the first phase_wrap copies shadow->outputs and clears pending.
//   - A phase_wrap in the same cycle as an accept commits the OLD shadow; the new one commits on a later wrap.
//   - A new accept while pending overwrites the shadow; only the latest is committed.
//  HOLD: freq_word held; dds_enable=1; waits for a new descriptor.
//  abort (has priority over accept and STEP):
//   - Next cycle: IDLE, busy=0, dds_enable=0, no done pulse.
//   - freq_word/wave_word/pwm_word hold; pending is cleared.
//  Async reset mid-sweep returns all outputs to reset values immediately.
// STRUCTURE
//  Shared package/include dds_pkg: wave encodings, mode encodings, state encoding, FREQ_W/PWM_W defaults.
//  One natural sub-module: dds_step_calc (combinational next-point + clamp + at-target flag).
//  Everything else is a single FSM + dwell counter + shadow regs in this file.
// TESTING
//  1. Reset values; then start=100, stop=130, step=10, dwell=3, single
//     -> freq_word 100,110,120,130, each held 4 cycles; done 1 cycle; busy=0; cfg_ready=1.
//  2. start=50, stop=20, step=20, dwell=1, single -> freq_word 50,30,20 (clamped); then done.
//  3. Ping-pong start=0, stop=4, step=2, dwell=0 -> freq_word 0,2,4,2,0,2... with a 2-cycle point period.
//  4. Wave change sin->square, no phase_wrap for 100 cycles -> wave_word stays 00.
//     Wrap pulse -> 10 the next cycle. Wrap coincident with accept -> no commit of the new value.
//  5. abort during DWELL of repeat sweep -> next cycle IDLE, busy=0, dds_enable=0, freq_word frozen, no done.
//  6. Accept in HOLD, plus async reset asserted mid-DWELL -> outputs at reset values same cycle, cfg_ready=1.

Source files
------------

// File: rtl/dds_pkg.sv
// dds_pkg: shared encodings and default widths for the DDS sweep sequencer.
//  FREQ_W/DWELL_W/PWM_W : default widths of frequency word, dwell counter, PWM duty
//  wave_e               : wave mux select (sin, tri, square, PWM)
//  mode_e               : sweep mode (single, repeat, ping-pong, reserved = single)
//  state_e              : sequencer states
package dds_pkg;
    localparam int FREQ_W  = 20;
    localparam int DWELL_W = 24;
    localparam int PWM_W   = 7;
    typedef enum logic [1:0] {WAVE_SIN, WAVE_TRI, WAVE_SQUARE, WAVE_PWM} wave_e;
    typedef enum logic [1:0] {MODE_SINGLE, MODE_REPEAT, MODE_PINGPONG, MODE_RSVD} mode_e;
    typedef enum logic [1:0] {ST_IDLE, ST_DWELL, ST_STEP, ST_HOLD} state_e;
endpackage

// File: rtl/dds_step_calc.sv
// dds_step_calc: combinational next frequency point with clamp to target.
//  i_freq       : current frequency word
//  i_target     : endpoint currently moved toward
//  i_alt_target : opposite endpoint, used when a ping-pong turn happens this step
//  i_step       : unsigned step magnitude
//  i_swap       : turn around at the target (ping-pong)
//  o_at_target  : current point is the target (a zero step never moves, so it counts as there)
//  o_next       : next point, clamped so it never passes the effective target
module dds_step_calc import dds_pkg::*; #(
    parameter int W = FREQ_W
) (
    input  logic [W-1:0] i_freq,
    input  logic [W-1:0] i_target,
    input  logic [W-1:0] i_alt_target,
    input  logic [W-1:0] i_step,
    input  logic         i_swap,
    output logic         o_at_target,
    output logic [W-1:0] o_next
);
    logic [W-1:0] w_tgt;
    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    assign o_at_target = (i_freq == i_target) || (i_step == '0);
    assign w_tgt       = (o_at_target && i_swap) ? i_alt_target : i_target;
    // One extra bit so that overflow past the top and borrow below zero are both visible
    assign w_sum  = {1'b0, i_freq} + {1'b0, i_step};
    assign w_diff = {1'b0, i_freq} - {1'b0, i_step};
    assign o_next = (w_tgt >= i_freq)
                  ? ((w_sum > {1'b0, w_tgt}) ? w_tgt : w_sum[W-1:0])
                  : ((w_diff[W] || (w_diff < {1'b0, w_tgt})) ? w_tgt : w_diff[W-1:0]);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: sweep sequencer driving the DDS phase accumulator and wave mux.
//  i_clk_100m/i_rst_n        : system clock, async active-low reset
//  i_cfg_valid/o_cfg_ready   : descriptor handshake (ready only in IDLE and HOLD)
//  i_cfg_start/stop/step     : sweep endpoints and unsigned step
//  i_cfg_dwell               : cycles per point (0 behaves as 1)
//  i_cfg_mode/wave/pwm       : sweep mode, wave select, PWM duty
//  i_abort                   : return to IDLE, outputs frozen
//  i_phase_wrap              : accumulator overflow pulse, commit point for wave/pwm
//  o_dds_enable              : datapath enable (sweeping or holding a final point)
//  o_freq_word               : frequency control word
//  o_wave_word/o_pwm_word    : committed wave select and PWM duty
//  o_busy/o_done             : sweep running / single sweep finished pulse
module dds_sweep_ctrl import dds_pkg::*; #(
    parameter int FREQ_W  = dds_pkg::FREQ_W,
    parameter int DWELL_W = dds_pkg::DWELL_W,
    parameter int PWM_W   = dds_pkg::PWM_W
) (
    input  logic               i_clk_100m,
    input  logic               i_rst_n,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [FREQ_W-1:0]  i_cfg_start,
    input  logic [FREQ_W-1:0]  i_cfg_stop,
    input  logic [FREQ_W-1:0]  i_cfg_step,
    input  logic [DWELL_W-1:0] i_cfg_dwell,
    input  logic [1:0]         i_cfg_mode,
    input  logic [1:0]         i_cfg_wave,
    input  logic [PWM_W-1:0]   i_cfg_pwm,
    input  logic               i_abort,
    input  logic               i_phase_wrap,
    output logic               o_dds_enable,
    output logic [FREQ_W-1:0]  o_freq_word,
    output logic [1:0]         o_wave_word,
    output logic [PWM_W-1:0]   o_pwm_word,
    output logic               o_busy,
    output logic               o_done
);
    state_e             r_state;
    mode_e              r_mode;
    logic [FREQ_W-1:0]  r_freq, r_start, r_stop, r_step;
    logic [DWELL_W-1:0] r_dwell, r_cnt;
    logic [1:0]         r_wave, r_shadow_wave;
    logic [PWM_W-1:0]   r_pwm, r_shadow_pwm;
    logic               r_pending, r_to_stop, r_busy, r_en, r_ready, r_done;
    logic               w_accept, w_single, w_at_target;
    logic [FREQ_W-1:0]  w_next;
    logic [DWELL_W-1:0] w_dwell_ld;
    assign w_accept   = i_cfg_valid && r_ready;
    assign w_single   = (r_mode == MODE_SINGLE) || (r_mode == MODE_RSVD);
    assign w_dwell_ld = (i_cfg_dwell == '0) ? DWELL_W'(1) : i_cfg_dwell;
    // Direction is implied by which endpoint is the current target (r_to_stop)
    dds_step_calc #(.W(FREQ_W)) u_calc (
        .i_freq       (r_freq),
        .i_target     (r_to_stop ? r_stop : r_start),
        .i_alt_target (r_to_stop ? r_start : r_stop),
        .i_step       (r_step),
        .i_swap       (r_mode == MODE_PINGPONG),
        .o_at_target  (w_at_target),
        .o_next       (w_next)
    );
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= MODE_SINGLE;
            r_freq        <= '0;
            r_start       <= '0;
            r_stop        <= '0;
            r_step        <= '0;
            r_dwell       <= DWELL_W'(1);
            r_cnt         <= DWELL_W'(1);
            r_wave        <= WAVE_SIN;
            r_shadow_wave <= WAVE_SIN;
            r_pwm         <= '0;
            r_shadow_pwm  <= '0;
            r_pending     <= 1'b0;
            r_to_stop     <= 1'b1;
            r_busy        <= 1'b0;
            r_en          <= 1'b0;
            r_ready       <= 1'b1;
            r_done        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Commit uses the shadow as it was before any accept in this same cycle
            if (i_phase_wrap && r_pending && !i_abort) begin
                r_wave    <= r_shadow_wave;
                r_pwm     <= r_shadow_pwm;
                r_pending <= 1'b0;
            end
            if (i_abort) begin
                r_state   <= ST_IDLE;
                r_busy    <= 1'b0;
                r_en      <= 1'b0;
                r_ready   <= 1'b1;
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_mode        <= mode_e'(i_cfg_mode);
                r_start       <= i_cfg_start;
                r_stop        <= i_cfg_stop;
                r_step        <= i_cfg_step;
                r_dwell       <= w_dwell_ld;
                r_cnt         <= w_dwell_ld;
                r_freq        <= i_cfg_start;
                r_to_stop     <= 1'b1;
                r_shadow_wave <= i_cfg_wave;
                r_shadow_pwm  <= i_cfg_pwm;
                r_pending     <= 1'b1;
                r_state       <= ST_DWELL;
                r_busy        <= 1'b1;
                r_en          <= 1'b1;
                r_ready       <= 1'b0;
            end else begin
                case (r_state)
                    ST_DWELL: begin
                        if (r_cnt == DWELL_W'(1)) r_state <= ST_STEP;
                        else r_cnt <= r_cnt - DWELL_W'(1);
                    end
                    ST_STEP: begin
                        if (w_at_target && w_single) begin
                            r_state <= ST_HOLD;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_done  <= 1'b1;
                        end else begin
                            r_freq    <= (w_at_target && r_mode == MODE_REPEAT) ? r_start : w_next;
                            r_to_stop <= r_to_stop ^ (w_at_target && r_mode == MODE_PINGPONG);
                            r_cnt     <= r_dwell;
                            r_state   <= ST_DWELL;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    assign o_cfg_ready  = r_ready;
    assign o_dds_enable = r_en;
    assign o_freq_word  = r_freq;
    assign o_wave_word  = r_wave;
    assign o_pwm_word   = r_pwm;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: self-checking bench for dds_sweep_ctrl (vector table, directed corners, random sweeps).
module tb_dds_sweep_ctrl;
    localparam int FW = 20;
    localparam int DW = 24;
    localparam int PW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [FW-1:0] cfg_start = '0;
    logic [FW-1:0] cfg_stop = '0;
    logic [FW-1:0] cfg_step = '0;
    logic [DW-1:0] cfg_dwell = '0;
    logic [1:0]    cfg_mode = '0;
    logic [1:0]    cfg_wave = '0;
    logic [PW-1:0] cfg_pwm = '0;
    logic          abort = 1'b0;
    logic          phase_wrap = 1'b0;
    logic          dds_enable;
    logic [FW-1:0] freq_word;
    logic [1:0]    wave_word;
    logic [PW-1:0] pwm_word;
    logic          busy;
    logic          done;

    dds_sweep_ctrl dut (
        .i_clk_100m   (clk),
        .i_rst_n      (rst_n),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_start  (cfg_start),
        .i_cfg_stop   (cfg_stop),
        .i_cfg_step   (cfg_step),
        .i_cfg_dwell  (cfg_dwell),
        .i_cfg_mode   (cfg_mode),
        .i_cfg_wave   (cfg_wave),
        .i_cfg_pwm    (cfg_pwm),
        .i_abort      (abort),
        .i_phase_wrap (phase_wrap),
        .o_dds_enable (dds_enable),
        .o_freq_word  (freq_word),
        .o_wave_word  (wave_word),
        .o_pwm_word   (pwm_word),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int exp_q[$];
    int path_q[$];
    int cyc_q[$];

    // Reference for the wave/pwm commit rule: latest accepted value waits for a wrap
    logic [1:0]    m_wave = '0, m_shadow_wave = '0;
    logic [PW-1:0] m_pwm = '0, m_shadow_pwm = '0;
    bit            m_pending = 1'b0;

    typedef struct {
        int start;
        int stop;
        int step;
        int dwell;
        int mode;
        int n;
        int pts[10];
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        if (abort) m_pending = 1'b0;
        else begin
            if (phase_wrap && m_pending) begin
                m_wave    = m_shadow_wave;
                m_pwm     = m_shadow_pwm;
                m_pending = 1'b0;
            end
            if (cfg_valid) begin
                m_shadow_wave = cfg_wave;
                m_shadow_pwm  = cfg_pwm;
                m_pending     = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("wave", 32'(wave_word), 32'(m_wave));
        check("pwm", 32'(pwm_word), 32'(m_pwm));
    endtask

    task automatic accept(input int s, input int p, input int st, input int d, input int m,
                          input int w, input int pw, input bit wrap);
        cfg_start  = FW'(s);
        cfg_stop   = FW'(p);
        cfg_step   = FW'(st);
        cfg_dwell  = DW'(d);
        cfg_mode   = 2'(m);
        cfg_wave   = 2'(w);
        cfg_pwm    = PW'(pw);
        cfg_valid  = 1'b1;
        phase_wrap = wrap;
        check("ready_at_accept", 32'(cfg_ready), 1);
        cycle();
        cfg_valid  = 1'b0;
        phase_wrap = 1'b0;
    endtask

    // Points visited from a to b: move by s, never past b; zero step stays put
    task automatic make_path(input longint a, input longint b, input longint s);
        longint x;
        x = a;
        path_q.delete();
        path_q.push_back(int'(a));
        if (s != 0)
            while (x != b) begin
                if (b >= a) x = (x + s > b) ? b : x + s;
                else        x = (x - s < b) ? b : x - s;
                path_q.push_back(int'(x));
            end
    endtask

    task automatic make_expect(input int s, input int p, input int st, input int m);
        exp_q.delete();
        make_path(s, p, st);
        if (m == 0 || m == 3) exp_q = path_q;
        else begin
            cyc_q = path_q;
            if (m == 2) begin
                make_path(p, s, st);
                for (int i = 1; i < path_q.size() - 1; i++) cyc_q.push_back(path_q[i]);
            end
            for (int i = 0; i < 10; i++) exp_q.push_back(cyc_q[i % cyc_q.size()]);
        end
    endtask

    // Runs one descriptor against exp_q; single ends in HOLD, loops are aborted in their last STEP
    task automatic run_sweep(input string tag, input int s, input int p, input int st,
                             input int d, input int m, input int w, input int pw);
        int  per;
        int  n;
        bit  single;
        per    = (d == 0) ? 2 : d + 1;
        n      = exp_q.size();
        single = (m == 0 || m == 3);
        accept(s, p, st, d, m, w, pw, ($urandom % 4) == 0);
        for (int t = 0; t < n * per; t++) begin
            check({tag, "_freq"}, 32'(freq_word), exp_q[t / per]);
            check({tag, "_busy"}, 32'(busy), 1);
            check({tag, "_ready_low"}, 32'(cfg_ready), 0);
            check({tag, "_done_low"}, 32'(done), 0);
            if (t == n * per - 1 && !single) abort = 1'b1;
            phase_wrap = ($urandom % 8) == 0;
            cycle();
            phase_wrap = 1'b0;
            abort = 1'b0;
        end
        if (single) begin
            check({tag, "_done"}, 32'(done), 1);
            check({tag, "_busy_end"}, 32'(busy), 0);
            check({tag, "_ready_end"}, 32'(cfg_ready), 1);
            check({tag, "_en_hold"}, 32'(dds_enable), 1);
            check({tag, "_freq_end"}, 32'(freq_word), exp_q[n - 1]);
            cycle();
            check({tag, "_done_pulse"}, 32'(done), 0);
            check({tag, "_freq_hold"}, 32'(freq_word), exp_q[n - 1]);
        end else begin
            check({tag, "_abort_busy"}, 32'(busy), 0);
            check({tag, "_abort_en"}, 32'(dds_enable), 0);
            check({tag, "_abort_done"}, 32'(done), 0);
            check({tag, "_abort_freq"}, 32'(freq_word), exp_q[n - 1]);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_freq"}, 32'(freq_word), 0);
        check({tag, "_wave"}, 32'(wave_word), 0);
        check({tag, "_pwm"}, 32'(pwm_word), 0);
        check({tag, "_en"}, 32'(dds_enable), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_ready"}, 32'(cfg_ready), 1);
    endtask

    initial begin
        tbl[0] = '{100, 130, 10, 3, 0, 4, '{100, 110, 120, 130, 0, 0, 0, 0, 0, 0}};
        tbl[1] = '{50, 20, 20, 1, 0, 3, '{50, 30, 20, 0, 0, 0, 0, 0, 0, 0}};
        tbl[2] = '{0, 4, 2, 0, 2, 8, '{0, 2, 4, 2, 0, 2, 4, 2, 0, 0}};
        tbl[3] = '{10, 15, 3, 0, 1, 8, '{10, 13, 15, 10, 13, 15, 10, 13, 0, 0}};
        tbl[4] = '{1048570, 1048575, 10, 0, 0, 2, '{1048570, 1048575, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[5] = '{5, 0, 7, 1, 0, 2, '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[6] = '{7, 9, 0, 2, 0, 1, '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[7] = '{3, 1, 1, 0, 3, 3, '{3, 2, 1, 0, 0, 0, 0, 0, 0, 0}};
        tbl[8] = '{1048575, 0, 0, 1, 2, 4, '{1048575, 1048575, 1048575, 1048575, 0, 0, 0, 0, 0, 0}};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Wave commit: nothing moves without a wrap, then the wrap commits
        accept(0, 0, 0, 3, 0, 2, 33, 1'b0);
        repeat (100) cycle();
        check("wave_no_wrap", 32'(wave_word), 0);
        phase_wrap = 1'b1;
        cycle();
        phase_wrap = 1'b0;
        check("wave_commit_sq", 32'(wave_word), 2);
        check("pwm_commit", 32'(pwm_word), 33);
        // Wrap with accept and nothing pending: new value is not committed
        accept(0, 0, 0, 1, 0, 1, 5, 1'b1);
        check("wave_coincident", 32'(wave_word), 2);
        repeat (5) cycle();
        // Overwrite the pending shadow, then a wrap+accept commits the older shadow
        accept(0, 0, 0, 1, 0, 3, 9, 1'b0);
        repeat (5) cycle();
        accept(0, 0, 0, 1, 0, 0, 1, 1'b1);
        check("wave_old_commit", 32'(wave_word), 3);
        check("pwm_old_commit", 32'(pwm_word), 9);
        repeat (3) cycle();
        phase_wrap = 1'b1;
        cycle();
        phase_wrap = 1'b0;
        check("wave_latest", 32'(wave_word), 0);
        check("pwm_latest", 32'(pwm_word), 1);

        // Abort in the middle of a dwell of a repeat sweep
        accept(200, 300, 5, 6, 1, 2, 7, 1'b0);
        repeat (2) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_en", 32'(dds_enable), 0);
        check("abort_ready", 32'(cfg_ready), 1);
        for (int i = 0; i < 10; i++) begin
            check("abort_no_done", 32'(done), 0);
            check("abort_freq", 32'(freq_word), 200);
            cycle();
        end

        // Async reset in the middle of a dwell
        accept(1000, 2000, 100, 10, 0, 1, 3, 1'b0);
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        m_wave = '0;
        m_pwm = '0;
        m_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 9; k++) begin
            exp_q.delete();
            for (int i = 0; i < tbl[k].n; i++) exp_q.push_back(tbl[k].pts[i]);
            run_sweep($sformatf("vec%0d", k), tbl[k].start, tbl[k].stop, tbl[k].step,
                      tbl[k].dwell, tbl[k].mode, k % 4, k * 11);
        end

        for (int k = 0; k < 20; k++) begin
            int s, p, st, d, m, rng;
            s   = (($urandom % 3) == 0) ? 1048575 - int'($urandom % 60) : int'($urandom % 300);
            p   = (($urandom % 3) == 0) ? 1048575 - int'($urandom % 60) : int'($urandom % 300);
            rng = (s > p) ? s - p : p - s;
            st  = (($urandom % 5) == 0) ? 0 : rng / int'(1 + $urandom % 6) + int'($urandom % 9);
            if (st > 1048575) st = 1048575;
            d   = int'($urandom % 4);
            m   = int'($urandom % 4);
            make_expect(s, p, st, m);
            run_sweep($sformatf("rnd%0d", k), s, p, st, d, m, int'($urandom % 4), int'($urandom % 128));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
